// File: rtl/decode_regfile_stage.sv
// Decode stage: slices a 32-bit RISC-V instruction into its fields and reads two operands
// from an internal register file. Write-backs bypass to same-cycle reads, and the outputs
// sit in a decode-to-execute register with valid, stall and flush.
module decode_regfile_stage #(
    parameter int XLEN     = 64,
    parameter int NUM_REGS = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [31:0]     instruction,
    input  logic            stall,
    input  logic            flush,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    output logic [6:0]      opcode,
    output logic [4:0]      rd,
    output logic [2:0]      funct3,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [6:0]      funct7,
    output logic [XLEN-1:0] read_data1,
    output logic [XLEN-1:0] read_data2
);

    localparam int AW = $clog2(NUM_REGS);

    logic [XLEN-1:0] regs [NUM_REGS];
    logic [4:0]      src1;
    logic [4:0]      src2;
    logic            wb_legal;
    logic [XLEN-1:0] src1_data;
    logic [XLEN-1:0] src2_data;

    assign src1     = instruction[19:15];
    assign src2     = instruction[24:20];
    assign wb_legal = wb_en && (wb_rd != 5'd0) && (32'(wb_rd) < NUM_REGS);

    // x0 and unimplemented addresses read as zero; a same-cycle write-back wins over storage
    function automatic logic [XLEN-1:0] read_port(input logic [4:0] s);
        logic [XLEN-1:0] value;
        if (s == 5'd0 || 32'(s) >= NUM_REGS) begin
            value = '0;
        end else if (wb_en && wb_rd == s) begin
            value = wb_data;
        end else begin
            value = regs[s[AW-1:0]];
        end
        return value;
    endfunction

    always_comb begin
        src1_data = read_port(src1);
        src2_data = read_port(src2);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_legal) begin
            regs[wb_rd[AW-1:0]] <= wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            opcode     <= '0;
            rd         <= '0;
            funct3     <= '0;
            rs1        <= '0;
            rs2        <= '0;
            funct7     <= '0;
            read_data1 <= '0;
            read_data2 <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (stall) begin
            // A stalled instruction must pick up write-backs to its own sources
            if (out_valid && wb_legal && wb_rd == rs1) begin
                read_data1 <= wb_data;
            end
            if (out_valid && wb_legal && wb_rd == rs2) begin
                read_data2 <= wb_data;
            end
        end else begin
            out_valid  <= in_valid;
            opcode     <= instruction[6:0];
            rd         <= instruction[11:7];
            funct3     <= instruction[14:12];
            rs1        <= src1;
            rs2        <= src2;
            funct7     <= instruction[31:25];
            read_data1 <= src1_data;
            read_data2 <= src2_data;
        end
    end

endmodule

// File: tb/tb_decode_regfile_stage.sv
// Bench for decode_regfile_stage: a 32-register and a 16-register instance share stimulus
// and are compared against an architectural model of registers plus the decode output.
module tb_decode_regfile_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] instruction = '0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [63:0] wb_data = '0;

    logic        out_valid_w [2];
    logic [6:0]  opcode_w    [2];
    logic [4:0]  rd_w        [2];
    logic [2:0]  funct3_w    [2];
    logic [4:0]  rs1_w       [2];
    logic [4:0]  rs2_w       [2];
    logic [6:0]  funct7_w    [2];
    logic [63:0] rdata1_w    [2];
    logic [63:0] rdata2_w    [2];

    int n_vec = 0;
    int n_err = 0;

    // Model: architectural register contents and the instruction/operands the stage should hold
    int          nr [2] = '{32, 16};
    logic [63:0] m_regs [2][32];
    logic        e_valid [2];
    logic        e_known [2];
    logic [31:0] e_instr [2];
    logic [63:0] e_d1 [2];
    logic [63:0] e_d2 [2];

    always #5 clk = ~clk;

    decode_regfile_stage #(.XLEN(64), .NUM_REGS(32)) dut32 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .instruction(instruction),
        .stall(stall), .flush(flush), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(out_valid_w[0]), .opcode(opcode_w[0]), .rd(rd_w[0]), .funct3(funct3_w[0]),
        .rs1(rs1_w[0]), .rs2(rs2_w[0]), .funct7(funct7_w[0]),
        .read_data1(rdata1_w[0]), .read_data2(rdata2_w[0])
    );

    decode_regfile_stage #(.XLEN(64), .NUM_REGS(16)) dut16 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .instruction(instruction),
        .stall(stall), .flush(flush), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(out_valid_w[1]), .opcode(opcode_w[1]), .rd(rd_w[1]), .funct3(funct3_w[1]),
        .rs1(rs1_w[1]), .rs2(rs2_w[1]), .funct7(funct7_w[1]),
        .read_data1(rdata1_w[1]), .read_data2(rdata2_w[1])
    );

    function automatic logic [31:0] enc(input logic [6:0] op, input logic [4:0] d,
                                        input logic [2:0] f3, input logic [4:0] s1,
                                        input logic [4:0] s2, input logic [6:0] f7);
        return {f7, s2, s1, f3, d, op};
    endfunction

    function automatic logic [63:0] model_read(input int k, input int s);
        if (s == 0 || s >= nr[k]) return 64'd0;
        if (wb_en && int'(wb_rd) == s) return wb_data;
        return m_regs[k][s];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        for (int k = 0; k < 2; k++) begin
            logic legal;
            legal = wb_en && wb_rd != 0 && int'(wb_rd) < nr[k];
            if (reset) begin
                for (int r = 0; r < 32; r++) m_regs[k][r] = '0;
                e_valid[k] = 1'b0;
                e_known[k] = 1'b1;
                e_instr[k] = '0;
                e_d1[k] = '0;
                e_d2[k] = '0;
            end else begin
                if (flush) begin
                    e_valid[k] = 1'b0;
                    e_known[k] = 1'b0;
                end else if (stall) begin
                    if (e_valid[k] && legal && wb_rd == e_instr[k][19:15]) e_d1[k] = wb_data;
                    if (e_valid[k] && legal && wb_rd == e_instr[k][24:20]) e_d2[k] = wb_data;
                end else begin
                    e_valid[k] = in_valid;
                    e_known[k] = in_valid;
                    e_instr[k] = instruction;
                    e_d1[k] = model_read(k, int'(instruction[19:15]));
                    e_d2[k] = model_read(k, int'(instruction[24:20]));
                end
                if (legal) m_regs[k][wb_rd] = wb_data;
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("out_valid[%0d]", k), 64'(out_valid_w[k]), 64'(e_valid[k]));
            if (e_known[k]) begin
                chk($sformatf("opcode[%0d]", k), 64'(opcode_w[k]), 64'(e_instr[k][6:0]));
                chk($sformatf("rd[%0d]", k),     64'(rd_w[k]),     64'(e_instr[k][11:7]));
                chk($sformatf("funct3[%0d]", k), 64'(funct3_w[k]), 64'(e_instr[k][14:12]));
                chk($sformatf("rs1[%0d]", k),    64'(rs1_w[k]),    64'(e_instr[k][19:15]));
                chk($sformatf("rs2[%0d]", k),    64'(rs2_w[k]),    64'(e_instr[k][24:20]));
                chk($sformatf("funct7[%0d]", k), 64'(funct7_w[k]), 64'(e_instr[k][31:25]));
                chk($sformatf("rdata1[%0d]", k), rdata1_w[k], e_d1[k]);
                chk($sformatf("rdata2[%0d]", k), rdata2_w[k], e_d2[k]);
            end
        end
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic drive(input logic rst, input logic v, input logic [31:0] ins,
                         input logic st, input logic fl, input logic we,
                         input logic [4:0] wr, input logic [63:0] wd);
        reset = rst; in_valid = v; instruction = ins; stall = st; flush = fl;
        wb_en = we; wb_rd = wr; wb_data = wd;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            e_valid[k] = 1'b0; e_known[k] = 1'b0; e_instr[k] = '0; e_d1[k] = '0; e_d2[k] = '0;
        end

        // reset, with a write-back that must be discarded
        drive(1, 0, '0, 0, 0, 1, 5'd4, 64'hDEAD);
        step();
        drive(1, 0, '0, 0, 0, 0, 0, 0);
        step();

        // add x1,x2,x3 straight out of reset
        drive(0, 1, 32'h003100B3, 0, 0, 0, 0, 0);
        step();
        chk("add_opcode", 64'(opcode_w[0]), 64'h33);
        chk("add_rs2", 64'(rs2_w[0]), 64'd3);

        // x2 and x3 written, then read through storage
        drive(0, 0, '0, 0, 0, 1, 5'd2, 64'h1111);
        step();
        drive(0, 0, '0, 0, 0, 1, 5'd3, 64'h2222);
        step();
        drive(0, 1, 32'h003100B3, 0, 0, 0, 0, 0);
        step();
        chk("stored_x2", rdata1_w[0], 64'h1111);
        chk("stored_x3", rdata2_w[1], 64'h2222);

        // same-cycle bypass with rs1 == rs2
        drive(0, 1, enc(7'h33, 5'd6, 3'd0, 5'd5, 5'd5, 7'd0), 0, 0, 1, 5'd5, 64'hABCD);
        step();
        chk("bypass_rd1", rdata1_w[1], 64'hABCD);
        chk("bypass_rd2", rdata2_w[0], 64'hABCD);

        // x0 and x20 writes (x20 is unimplemented in the 16-register instance)
        drive(0, 0, '0, 0, 0, 1, 5'd0, 64'h77);
        step();
        drive(0, 0, '0, 0, 0, 1, 5'd20, 64'hFFFF);
        step();
        drive(0, 1, enc(7'h33, 5'd1, 3'd0, 5'd0, 5'd20, 7'd0), 0, 0, 0, 0, 0);
        step();
        chk("x0_reads_zero", rdata1_w[0], 64'd0);
        chk("x20_16regs_zero", rdata2_w[1], 64'd0);

        // held-operand refresh during stall
        drive(0, 1, enc(7'h13, 5'd9, 3'd2, 5'd7, 5'd8, 7'd0), 0, 0, 0, 0, 0);
        step();
        drive(0, 1, enc(7'h03, 5'd4, 3'd1, 5'd1, 5'd1, 7'd0), 1, 0, 0, 0, 0);
        step();
        drive(0, 1, enc(7'h03, 5'd4, 3'd1, 5'd1, 5'd1, 7'd0), 1, 0, 1, 5'd7, 64'h55);
        step();
        chk("stall_refresh", rdata1_w[0], 64'h55);
        chk("stall_hold_rd", 64'(rd_w[1]), 64'd9);
        drive(0, 1, enc(7'h33, 5'd2, 3'd0, 5'd7, 5'd2, 7'd0), 0, 0, 0, 0, 0);
        step();

        // flush beats stall, then reset beats stall
        drive(0, 1, 32'h003100B3, 1, 1, 0, 0, 0);
        step();
        chk("flush_over_stall", 64'(out_valid_w[0]), 64'd0);
        drive(0, 1, 32'h003100B3, 0, 0, 0, 0, 0);
        step();
        drive(1, 1, 32'h003100B3, 1, 0, 1, 5'd3, 64'h99);
        step();
        chk("reset_rdata1", rdata1_w[0], 64'd0);

        // randomized traffic
        for (int i = 0; i < 500; i++) begin
            logic [4:0] s1, s2;
            drive(($urandom_range(0, 99) < 2), $urandom_range(0, 3) != 0, $urandom,
                  ($urandom_range(0, 99) < 25), ($urandom_range(0, 99) < 8),
                  $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)),
                  {$urandom, $urandom});
            s1 = ($urandom_range(0, 3) == 0) ? wb_rd : 5'($urandom_range(0, 31));
            s2 = ($urandom_range(0, 3) == 0) ? s1 : 5'($urandom_range(0, 31));
            instruction[19:15] = s1;
            instruction[24:20] = s2;
            step();
        end

        // after a final reset every register reads zero
        drive(1, 0, '0, 1, 0, 0, 0, 0);
        step();
        for (int r = 0; r < 32; r += 2) begin
            drive(0, 1, enc(7'h33, 5'd1, 3'd0, 5'(r), 5'(r + 1), 7'd0), 0, 0, 0, 0, 0);
            step();
            chk("post_reset_zero", rdata1_w[0] | rdata2_w[0], 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/decode_regfile_stage.md
Name: decode_regfile_stage

Overview:
- Parametrised successor to the read-only decode/register-file wrapper.
- Splits the 32-bit RISC-V instruction into its fields and reads two source operands from an internal register file.
- Accepts a write-back port with same-cycle bypass, and registers everything into a decode-to-execute pipeline register with valid, stall and flush.
- Sits between instruction fetch and the ALU/execute stage.

Parameters:
- XLEN, 64, data width of each register and of the read/write data ports.
- NUM_REGS, 32, number of architectural registers implemented. Legal values are 16 or 32. Addresses >= NUM_REGS read as zero and ignore writes.

Ports:
- clk  input  1  pipeline and register-file clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high.
- in_valid  input  1  instruction present this cycle.
- instruction  input  32  raw instruction word.
- stall  input  1  hold the output pipeline register.
- flush  input  1  kill the output pipeline register contents.
- wb_en  input  1  write-back enable.
- wb_rd  input  5  write-back destination address.
- wb_data  input  XLEN  write-back data.
- out_valid  output  1  output register holds a live instruction.
- opcode  output  7  instruction[6:0], registered.
- rd  output  5  instruction[11:7], registered.
- funct3  output  3  instruction[14:12], registered.
- rs1  output  5  instruction[19:15], registered.
- rs2  output  5  instruction[24:20], registered.
- funct7  output  7  instruction[31:25], registered.
- read_data1  output  XLEN  operand for rs1, registered.
- read_data2  output  XLEN  operand for rs2, registered.

Behaviour:
- Reset (sync, active-high):
  - All NUM_REGS registers cleared to 0.
  - out_valid=0; every field output and read_data1/2 = 0.
  - A write-back presented in a reset cycle is discarded.
  - Reset mid-stall or mid-flush wins over both.
- Register file:
  - Write occurs on the clock edge when wb_en=1, wb_rd!=0 and wb_rd<NUM_REGS.
  - x0 always reads 0 and is never written.
- Combinational read with bypass, for each source s in {rs1, rs2} taken from the incoming instruction:
  - 0 if s==0 or s>=NUM_REGS.
  - Otherwise wb_data if wb_en=1 and wb_rd==s.
  - Otherwise the stored register value.
- Output register update, priority order:
  1. reset: clear as above.
  2. flush=1: out_valid<=0; fields and data hold their values (don't-care). Flush overrides stall.
  3. stall=1:
     - All outputs hold.
     - Exception: if out_valid=1, wb write is legal and wb_rd equals the held rs1 (or rs2), read_data1 (or read_data2) is updated to wb_data on that edge.
     - This held-operand refresh is required so a stalled instruction never carries stale data.
  4. Otherwise (load):
     - out_valid<=in_valid.
     - Fields and read_data1/2 are loaded from the instruction and the bypassed reads.
     - Fields and data are loaded even when in_valid=0 (don't-care contents).
- Latency: one cycle from instruction to outputs. A write-back is visible to an instruction decoded in the same cycle via bypass, and from storage in any later cycle.
- Simultaneous rs1==rs2: both operands receive the same value, including the bypass and held-refresh paths.
- Field extraction: pure bit slicing, no sign extension, no immediate generation.

Test Plan:
- Reset, then instruction 0x003100B3 (add x1,x2,x3) with in_valid=1 -> next cycle out_valid=1, opcode=0x33, rd=1, rs1=2, rs2=3, funct3=0, funct7=0, read_data1=read_data2=0.
- Write x2=0x1111, x3=0x2222, then decode add x1,x2,x3 -> read_data1=0x1111, read_data2=0x2222.
- Same cycle: wb_en=1, wb_rd=5, wb_data=0xABCD, and decode of rs1=rs2=5 -> read_data1=read_data2=0xABCD one cycle later.
- Writes to x0 and, with NUM_REGS=16, to x20 (value 0xFFFF) -> later reads of x0 and x20 return 0.
- Decode rs1=7 with stall held high, then wb x7=0x55 during the stall -> read_data1 becomes 0x55 while rd/opcode/out_valid hold; release stall -> next instruction loads normally.
- flush and stall asserted together with out_valid=1 -> out_valid=0 next cycle. Then assert reset while stalled -> out_valid=0, all outputs 0, and all registers read 0.
